// File: rtl/udc_sweep_ctrl_pkg.sv
// Shared types for the sweep controller: FSM state encoding and direction constants.
// Optional freeze feature elsewhere is enabled with UDC_CTRL_PAUSE_EN.
package udc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/udc_sweep_ctrl_if.sv
// Control/status bundle between the surrounding logic (master) and the sweep controller (slave).
// The pause signal exists only when UDC_CTRL_PAUSE_EN is defined.
interface udc_sweep_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int SW_W  = 4
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [SW_W-1:0]  cycles;
`ifdef UDC_CTRL_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic [SW_W-1:0]  sweep;
    logic             done;
    logic             err;

`ifdef UDC_CTRL_PAUSE_EN
    modport master (output start, stop, lo, hi, cycles, pause,
                    input  count, dir, busy, sweep, done, err);
    modport slave  (input  start, stop, lo, hi, cycles, pause,
                    output count, dir, busy, sweep, done, err);
`else
    modport master (output start, stop, lo, hi, cycles,
                    input  count, dir, busy, sweep, done, err);
    modport slave  (input  start, stop, lo, hi, cycles,
                    output count, dir, busy, sweep, done, err);
`endif

endinterface

// File: rtl/udc_sweep_ctrl_core.sv
// Up/down count register with synchronous load; load wins over a count step.
module udc_core
    import udc_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register: reset, load, +/-1 step or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            if (dir == DIR_DOWN) begin
                count_r <= count_r - WIDTH'(1);
            end else begin
                count_r <= count_r + WIDTH'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/udc_sweep_ctrl.sv
// Sweep controller: runs the counter lo->hi->lo for a captured number of sweeps or until stopped.
// Define UDC_CTRL_PAUSE_EN to add a pause input that freezes a run in progress.
module udc_sweep_ctrl
    import udc_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SW_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    udc_sweep_ctrl_if.slave bus
);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] lo_r, hi_r, lo_nxt_s, hi_nxt_s;
    logic [SW_W-1:0]  cyc_r, cyc_nxt_s;
    logic [SW_W-1:0]  sweep_r, sweep_nxt_s, sweep_inc_s;
    logic             dir_r, dir_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             err_r, err_nxt_s;
    logic             core_load_s, core_en_s, core_dir_s;
    logic [WIDTH-1:0] count_s;
    logic             pause_s;

`ifdef UDC_CTRL_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    // Sweep progress saturates so an endless run never wraps the counter back to zero.
    assign sweep_inc_s = (sweep_r == {SW_W{1'b1}}) ? sweep_r : sweep_r + SW_W'(1);

    udc_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load_s),
        .load_val (bus.lo),
        .en       (core_en_s),
        .dir      (core_dir_s),
        .count    (count_s)
    );

    // Next-state and next-output logic; turnarounds step the core so hi-1 / lo+1 follow directly.
    always_comb begin
        state_nxt_s = state_r;
        lo_nxt_s    = lo_r;
        hi_nxt_s    = hi_r;
        cyc_nxt_s   = cyc_r;
        sweep_nxt_s = sweep_r;
        dir_nxt_s   = dir_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        core_load_s = 1'b0;
        core_en_s   = 1'b0;
        core_dir_s  = DIR_UP;
        case (state_r)
            IDLE: begin
                busy_nxt_s = 1'b0;
                if (bus.start) begin
                    if (bus.lo < bus.hi) begin
                        lo_nxt_s    = bus.lo;
                        hi_nxt_s    = bus.hi;
                        cyc_nxt_s   = bus.cycles;
                        sweep_nxt_s = {SW_W{1'b0}};
                        dir_nxt_s   = DIR_UP;
                        busy_nxt_s  = 1'b1;
                        core_load_s = 1'b1;
                        state_nxt_s = UP;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            UP: begin
                if (bus.stop) begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else if (pause_s) begin
                    state_nxt_s = UP;
                end else if (count_s != hi_r) begin
                    core_en_s = 1'b1;
                end else begin
                    core_en_s   = 1'b1;
                    core_dir_s  = DIR_DOWN;
                    dir_nxt_s   = DIR_DOWN;
                    state_nxt_s = DOWN;
                end
            end
            DOWN: begin
                if (bus.stop) begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else if (pause_s) begin
                    state_nxt_s = DOWN;
                end else if (count_s != lo_r) begin
                    core_en_s  = 1'b1;
                    core_dir_s = DIR_DOWN;
                end else begin
                    sweep_nxt_s = sweep_inc_s;
                    if ((cyc_r != {SW_W{1'b0}}) && (sweep_inc_s == cyc_r)) begin
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        core_en_s   = 1'b1;
                        dir_nxt_s   = DIR_UP;
                        state_nxt_s = UP;
                    end
                end
            end
            DONE: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, captured run parameters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            lo_r    <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            cyc_r   <= {SW_W{1'b0}};
            sweep_r <= {SW_W{1'b0}};
            dir_r   <= DIR_UP;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            lo_r    <= lo_nxt_s;
            hi_r    <= hi_nxt_s;
            cyc_r   <= cyc_nxt_s;
            sweep_r <= sweep_nxt_s;
            dir_r   <= dir_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.count = count_s;
    assign bus.dir   = dir_r;
    assign bus.busy  = busy_r;
    assign bus.sweep = sweep_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_udc_sweep_ctrl.sv
// Directed self-checking bench for udc_sweep_ctrl (pause scenario built only with UDC_CTRL_PAUSE_EN).
module tb_udc_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    udc_sweep_ctrl_if #(.WIDTH(4), .SW_W(4)) bus ();

    udc_sweep_ctrl #(.WIDTH(4), .SW_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.lo = 4'd0; bus.hi = 4'd0; bus.cycles = 4'd0;
`ifdef UDC_CTRL_PAUSE_EN
        bus.pause = 1'b0;
`endif
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.dir   !== 1'b0) begin bad++; $display("FAIL reset_dir got=%0b exp=0", bus.dir); end
        total++; if (bus.busy  !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.sweep !== 4'd0) begin bad++; $display("FAIL reset_sweep got=%0d exp=0", bus.sweep); end
        total++; if (bus.done  !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        total++; if (bus.err   !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_single_sweep();
        logic [3:0] exp_cnt [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
        logic       exp_dir [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.lo = 4'd2; bus.hi = 4'd5; bus.cycles = 4'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // Changing inputs mid-run must not disturb the captured limits.
        bus.lo = 4'd0; bus.hi = 4'd15; bus.cycles = 4'd0;
        for (int i = 0; i < 7; i++) begin
            total++; if (bus.count !== exp_cnt[i]) begin bad++; $display("FAIL sweep1_count[%0d] got=%0d exp=%0d", i, bus.count, exp_cnt[i]); end
            total++; if (bus.dir !== exp_dir[i]) begin bad++; $display("FAIL sweep1_dir[%0d] got=%0b exp=%0b", i, bus.dir, exp_dir[i]); end
            total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL sweep1_busy[%0d] busy=%0b done=%0b exp busy=1 done=0", i, bus.busy, bus.done); end
            tick();
        end
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL sweep1_done done=%0b busy=%0b exp done=1 busy=0", bus.done, bus.busy); end
        total++; if (bus.sweep !== 4'd1) begin bad++; $display("FAIL sweep1_sweep got=%0d exp=1", bus.sweep); end
        total++; if (bus.count !== 4'd2) begin bad++; $display("FAIL sweep1_hold got=%0d exp=2", bus.count); end
        tick();
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL sweep1_idle done=%0b busy=%0b exp 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_reject();
        logic [3:0] los [2] = '{4'd7, 4'd9};
        logic [3:0] his [2] = '{4'd7, 4'd3};
        for (int i = 0; i < 2; i++) begin
            bus.lo = los[i]; bus.hi = his[i]; bus.cycles = 4'd1; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL reject_err[%0d] got=%0b exp=1", i, bus.err); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reject_busy[%0d] got=%0b exp=0", i, bus.busy); end
            total++; if (bus.count !== 4'd2) begin bad++; $display("FAIL reject_count[%0d] got=%0d exp=2", i, bus.count); end
            tick();
            total++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reject_after[%0d] err=%0b busy=%0b exp 0 0", i, bus.err, bus.busy); end
        end
    endtask

    task automatic test_long_run();
        int busy_n = 0, done_n = 0, step_err = 0;
        int prev = 0;
        logic prev_busy = 1'b0;
        bus.lo = 4'd0; bus.hi = 4'd15; bus.cycles = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy === 1'b1) begin
                busy_n++;
                if (prev_busy && ((int'(bus.count) - prev != 1) && (prev - int'(bus.count) != 1))) step_err++;
            end
            if (bus.done === 1'b1) done_n++;
            prev = int'(bus.count);
            prev_busy = bus.busy;
            tick();
        end
        total++; if (busy_n != 61) begin bad++; $display("FAIL long_busy_cycles got=%0d exp=61", busy_n); end
        total++; if (done_n != 1) begin bad++; $display("FAIL long_done_pulses got=%0d exp=1", done_n); end
        total++; if (step_err != 0) begin bad++; $display("FAIL long_step_errors got=%0d exp=0", step_err); end
        total++; if (bus.sweep !== 4'd2) begin bad++; $display("FAIL long_sweep got=%0d exp=2", bus.sweep); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL long_final_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_stop();
        bus.lo = 4'd1; bus.hi = 4'd3; bus.cycles = 4'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 19; k++) begin
            if (k == 10) begin
                bus.start = 1'b1; bus.lo = 4'd0; bus.hi = 4'd15; bus.cycles = 4'd1;
            end
            tick();
            if (k == 10) begin
                bus.start = 1'b0;
                total++; if (bus.count !== 4'd2 || bus.err !== 1'b0) begin bad++; $display("FAIL stop_start_ignored count=%0d err=%0b exp 2 0", bus.count, bus.err); end
            end
        end
        total++; if (bus.count !== 4'd2 || bus.dir !== 1'b1) begin bad++; $display("FAIL stop_pre count=%0d dir=%0b exp 2 1", bus.count, bus.dir); end
        total++; if (bus.sweep !== 4'd4) begin bad++; $display("FAIL stop_pre_sweep got=%0d exp=4", bus.sweep); end
        bus.stop = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL stop_idle busy=%0b done=%0b exp 0 0", bus.busy, bus.done); end
        total++; if (bus.count !== 4'd2 || bus.sweep !== 4'd4) begin bad++; $display("FAIL stop_hold count=%0d sweep=%0d exp 2 4", bus.count, bus.sweep); end
        tick();
        bus.stop = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 4'd2) begin bad++; $display("FAIL stop_after busy=%0b done=%0b count=%0d exp 0 0 2", bus.busy, bus.done, bus.count); end
    endtask

    task automatic test_reset_mid_run();
        bus.lo = 4'd1; bus.hi = 4'd6; bus.cycles = 4'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        total++; if (bus.count !== 4'd4 || bus.dir !== 1'b1) begin bad++; $display("FAIL midrst_pre count=%0d dir=%0b exp 4 1", bus.count, bus.dir); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.count !== 4'd0 || bus.dir !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_state count=%0d dir=%0b busy=%0b exp 0 0 0", bus.count, bus.dir, bus.busy); end
        total++; if (bus.sweep !== 4'd0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL midrst_status sweep=%0d done=%0b err=%0b exp 0 0 0", bus.sweep, bus.done, bus.err); end
        tick();
        total++; if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin bad++; $display("FAIL midrst_idle busy=%0b count=%0d exp 0 0", bus.busy, bus.count); end
    endtask

`ifdef UDC_CTRL_PAUSE_EN
    task automatic test_pause();
        int waited = 0;
        bus.lo = 4'd0; bus.hi = 4'd7; bus.cycles = 4'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        bus.pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (bus.count !== 4'd3 || bus.busy !== 1'b1 || bus.dir !== 1'b0) begin bad++; $display("FAIL pause_freeze[%0d] count=%0d busy=%0b dir=%0b exp 3 1 0", k, bus.count, bus.busy, bus.dir); end
        end
        bus.pause = 1'b0;
        tick();
        total++; if (bus.count !== 4'd4) begin bad++; $display("FAIL pause_resume got=%0d exp=4", bus.count); end
        while (bus.done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL pause_done_timeout waited=%0d", waited); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_sweep();
        test_reject();
        test_long_run();
        test_stop();
        test_reset_mid_run();
`ifdef UDC_CTRL_PAUSE_EN
        test_pause();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udc_sweep_ctrl.md
# udc_sweep_ctrl

Sweep controller for the synchronous up/down counter datapath. On a start request it loads a programmed lower limit and drives the counter up to an upper limit and back down (one "sweep"), for a programmed number of sweeps or until stopped. It owns the count register and the direction select (`dir` = counter `c`: 0 up, 1 down), and reports busy/done/error status to the surrounding control logic.

## Interface
- `WIDTH`, default 4: count and limit width.
- `SW_W`, default 4: width of sweep-count request and progress.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort a run; sampled in UP/DOWN.
- `lo`  in  WIDTH  lower limit, captured on accepted start.
- `hi`  in  WIDTH  upper limit, captured on accepted start.
- `cycles`  in  SW_W  sweeps to run, captured on accepted start; 0 = run until stop.
- `pause`  in  1  freeze; present only with `UDC_CTRL_PAUSE_EN`.
- `count`  out  WIDTH  current count.
- `dir`  out  1  0 = counting up, 1 = counting down.
- `busy`  out  1  high in UP and DOWN.
- `sweep`  out  SW_W  completed sweeps in current run.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on rejected start.

## Operation
- States: IDLE, UP, DOWN, DONE.
- Reset (any state, mid-run included): state IDLE, `count`=0, `dir`=0, `busy`=0, `sweep`=0, `done`=0, `err`=0; captured limits cleared.
- IDLE: `start` with `lo < hi` → capture `lo`/`hi`/`cycles`, `count`←`lo`, `sweep`←0, state UP. `start` with `lo >= hi` → `err` pulse next cycle, stay IDLE, `count` unchanged. `stop` ignored.
- UP (`dir`=0): if `count != hi` → `count`+1; else state DOWN, `count`←`hi`−1.
- DOWN (`dir`=1): if `count != lo` → `count`−1; else sweep complete: `sweep`+1. If `cycles != 0` and `sweep`+1 == `cycles` → state DONE, `count` holds `lo`. Otherwise → state UP, `count`←`lo`+1.
- `sweep` saturates at all-ones when `cycles`=0 while counting continues.
- DONE: `done`=1 for this single cycle, `count` holds, next state IDLE.
- `stop` in UP/DOWN wins over all transitions: next state IDLE, `count` and `sweep` hold, no `done`.
- `start` outside IDLE ignored; no `err`.
- Limits are used only as captured; input changes mid-run have no effect.
- `count` never leaves [`lo`,`hi`] during a run; no wrap-around possible.

## Timing
- Start-to-first-count latency: 1 cycle (`count`=`lo`, `busy`=1 in cycle after start edge).
- First sweep: 2·(`hi`−`lo`)+1 cycles in UP/DOWN; each later sweep: 2·(`hi`−`lo`) cycles (`lo` shared at turnaround).
- `hi` and `lo` each appear for exactly one cycle per turnaround.
- `done` asserts the cycle after the final `count`=`lo` cycle; `busy` low in that cycle.
- `err` asserts one cycle after the rejected start edge.
- All outputs registered.

## Configuration
- `UDC_CTRL_PAUSE_EN` defined: `pause` port exists; while high in UP/DOWN, `count`, `sweep`, `dir` and state freeze; `busy` stays high; `stop` still honoured. `pause` ignored in IDLE/DONE.
- Undefined: no `pause` port; behaviour as above without freeze.

## Structure
- Package `udc_ctrl_pkg`: state enum (IDLE, UP, DOWN, DONE), constants `DIR_UP`=0, `DIR_DOWN`=1.
- Sub-module `udc_core`: WIDTH-bit register with load, enable and direction (±1). Controller FSM drives its load value, enable and `dir`.

## Test plan
- `lo`=2, `hi`=5, `cycles`=1, start → `count` 2,3,4,5,4,3,2 with `dir` 0,0,0,0,1,1,1; then `done`=1, `sweep`=1, IDLE.
- `lo`=0, `hi`=15, `cycles`=2 → 31 + 30 = 61 busy cycles, `count` never wraps, `done` once, `sweep`=2.
- `lo`=7, `hi`=7 start → `err` pulse, `busy` stays 0, `count` unchanged; `lo`=9, `hi`=3 likewise.
- `cycles`=0, `lo`=1, `hi`=3, `stop` after 20 cycles → IDLE next cycle, `count` holds, no `done`.
- Assert `rst` mid-DOWN with `count`=4 → all outputs 0 next cycle; `start` during run ignored.
- With `UDC_CTRL_PAUSE_EN`: `pause` for 5 cycles at `count`=3 going up → `count`=3 frozen, then resumes 4; without the macro, the `pause` port is absent.
